jt053246_dma: RTL and testbench

- Sprite-table DMA engine for the 053246/053244 sprite generator.
- Once per frame, or on a CPU trigger, it clears the internal object cache, then copies the object table from external sprite RAM into it.
- The cache is two 1024×16 banks, even and odd words. This block drives only their write port; the scanner reads the cache at {obj[7:0], sub[1:0]}.
- In 053246 mode, objects are re-slotted by their priority byte.

---
 rtl/jt053246_dma.sv | 152 +++++++++++++++
 tb/tb_jt053246_dma.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt053246_dma.sv
// Sprite-table DMA for the 053246/053244: clears the object cache, then copies
// the object table from sprite RAM, re-slotting by priority byte in 053246 mode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a vs edge (053246) or CPU trigger (053244)
// ST_CLEAR | zeroing both cache banks, one row per tick
// ST_COPY  | presenting read addresses; writing back the previous word
// ST_LAST  | write-back of the final word, no read issued
module jt053246_dma (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl2_cen,
    input  logic        dma_en,
    input  logic        dma_trig,
    input  logic        k44_en,
    input  logic        hs,
    input  logic        vs,
    output logic [12:0] dma_addr,
    input  logic [15:0] dma_data,
    output logic        dma_bsy,
    output logic        dma_weh,
    output logic        dma_wel,
    output logic [10:0] dma_wr_addr,
    output logic [15:0] dma_din,
    output logic        flicker
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_COPY  = 2'd2;
    localparam logic [1:0] ST_LAST  = 2'd3;

    logic [1:0]  st_q, st_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] rd_q, rd_d;
    logic        mode_q, mode_d;
    logic [7:0]  slot_q, slot_d;
    logic        valid_q, valid_d;
    logic        vs_q;
    logic        flick_q;

    logic        vs_rise;
    logic        start;
    logic        wb_act;
    logic [10:0] wb_ptr;
    logic [7:0]  slot_eff;
    logic        valid_eff;
    logic        unused_hs;

    assign unused_hs = hs;
    assign vs_rise   = vs & ~vs_q;
    assign start     = k44_en ? dma_trig : (dma_en & vs_rise);

    // Read data lags its address by one tick, so the word being written back
    // is the one addressed on the previous tick (the held address in ST_LAST).
    always_comb begin
        wb_act = ((st_q == ST_COPY) && (rd_q != 11'd0)) || (st_q == ST_LAST);
        wb_ptr = (st_q == ST_LAST) ? rd_q : rd_q - 11'd1;
        if (wb_ptr[2:0] == 3'd0) begin
            slot_eff  = mode_q ? wb_ptr[10:3] : dma_data[7:0];
            valid_eff = mode_q | dma_data[15];
        end else begin
            slot_eff  = slot_q;
            valid_eff = valid_q;
        end
    end

    always_comb begin
        dma_wr_addr = 11'd0;
        dma_din     = 16'd0;
        dma_wel     = 1'b0;
        dma_weh     = 1'b0;
        if (st_q == ST_CLEAR) begin
            dma_wr_addr = {~cnt_q[9:0], 1'b0};
            dma_wel     = pxl2_cen;
            dma_weh     = pxl2_cen;
        end else if (wb_act) begin
            dma_wr_addr = {slot_eff, wb_ptr[2:0]};
            dma_din     = dma_data;
            dma_wel     = pxl2_cen & valid_eff & ~wb_ptr[0];
            dma_weh     = pxl2_cen & valid_eff & wb_ptr[0];
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        mode_d  = mode_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        if (wb_act && (wb_ptr[2:0] == 3'd0)) begin
            slot_d  = slot_eff;
            valid_d = valid_eff;
        end
        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    st_d   = ST_CLEAR;
                    cnt_d  = 11'd1023;
                    mode_d = k44_en;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == 11'd0) begin
                    st_d  = ST_COPY;
                    cnt_d = mode_q ? 11'd1023 : 11'd2047;
                    rd_d  = 11'd0;
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            ST_COPY: begin
                if (cnt_q == 11'd0) begin
                    st_d = ST_LAST;
                end else begin
                    cnt_d = cnt_q - 11'd1;
                    rd_d  = rd_q + 11'd1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            cnt_q   <= 11'd0;
            rd_q    <= 11'd0;
            mode_q  <= 1'b0;
            slot_q  <= 8'd0;
            valid_q <= 1'b0;
            vs_q    <= 1'b0;
            flick_q <= 1'b0;
        end else if (pxl2_cen) begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            mode_q  <= mode_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            vs_q    <= vs;
            if (vs_rise) flick_q <= ~flick_q;
        end
    end

    assign dma_bsy  = (st_q != ST_IDLE);
    assign dma_addr = {2'b00, rd_q};
    assign flicker  = flick_q;

endmodule

// File: tb/tb_jt053246_dma.sv
// Bench for jt053246_dma: a spec-level model produces the ordered list of cache
// writes for each DMA; the compare process matches every DUT write against it.
module tb_jt053246_dma;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] din;
        logic        wel;
        logic        weh;
    } wr_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        pxl2_cen = 1'b1;
    logic        dma_en   = 1'b0;
    logic        dma_trig = 1'b0;
    logic        k44_en   = 1'b0;
    logic        hs       = 1'b0;
    logic        vs       = 1'b0;
    logic [15:0] dma_data = 16'h0;
    logic [12:0] dma_addr;
    logic        dma_bsy, dma_weh, dma_wel, flicker;
    logic [10:0] dma_wr_addr;
    logic [15:0] dma_din;

    logic [15:0] ram   [0:8191];
    logic [15:0] cache [0:2047];
    wr_t         exp_q [$];
    wr_t         act_w, exp_w;

    int   vectors     = 0;
    int   miscompares = 0;
    int   busy_cycles = 0;
    int   clr_cnt     = 0;
    int   cen_div     = 1;
    int   cyc         = 0;
    bit   checking    = 1'b1;
    logic flick_exp   = 1'b0;

    jt053246_dma dut (
        .clk         (clk),
        .rst         (rst),
        .pxl2_cen    (pxl2_cen),
        .dma_en      (dma_en),
        .dma_trig    (dma_trig),
        .k44_en      (k44_en),
        .hs          (hs),
        .vs          (vs),
        .dma_addr    (dma_addr),
        .dma_data    (dma_data),
        .dma_bsy     (dma_bsy),
        .dma_weh     (dma_weh),
        .dma_wel     (dma_wel),
        .dma_wr_addr (dma_wr_addr),
        .dma_din     (dma_din),
        .flicker     (flicker)
    );

    initial forever #5 clk = ~clk;
    initial forever #37 hs = ~hs;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        pxl2_cen = ((cyc % cen_div) == 0);
    end

    // Synchronous sprite RAM: data appears on the tick after its address.
    initial forever begin
        @(posedge clk);
        if (pxl2_cen) dma_data <= ram[dma_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_tick();
        do @(negedge clk); while (!pxl2_cen);
    endtask

    // Compare process: every DUT write on a clock-enable tick must be the next model write.
    initial forever begin
        @(negedge clk);
        if (!rst && checking) begin
            if (dma_bsy) busy_cycles++;
            if (!pxl2_cen) begin
                chk("we_gated", {30'd0, dma_wel, dma_weh}, 32'd0);
            end else if (dma_wel || dma_weh) begin
                act_w = {dma_wr_addr, dma_din, dma_wel, dma_weh};
                if (dma_wel && dma_weh) clr_cnt++;
                if (dma_wel) cache[{dma_wr_addr[10:1], 1'b0}] = dma_din;
                if (dma_weh) cache[{dma_wr_addr[10:1], 1'b1}] = dma_din;
                chk("exp_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    chk("write", 32'(act_w), 32'(exp_w));
                end
            end
        end
    end

    function automatic void build_exp(input bit k44, input int n_obj);
        wr_t         e;
        logic [15:0] w0;
        logic [7:0]  slot;
        bit          valid;
        exp_q.delete();
        for (int r = 0; r < 1024; r++) begin
            e.addr = {r[9:0], 1'b0};
            e.din  = 16'h0;
            e.wel  = 1'b1;
            e.weh  = 1'b1;
            exp_q.push_back(e);
        end
        for (int o = 0; o < n_obj; o++) begin
            w0    = ram[o * 8];
            slot  = k44 ? o[7:0] : w0[7:0];
            valid = k44 || w0[15];
            if (valid) begin
                for (int w = 0; w < 8; w++) begin
                    e.addr = {slot, w[2:0]};
                    e.din  = ram[o * 8 + w];
                    e.wel  = ~w[0];
                    e.weh  = w[0];
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic fill_ram_a();
        for (int i = 0; i < 8192; i++) ram[i] = 16'h0;
        for (int o = 0; o < 256; o++) begin
            for (int w = 1; w < 8; w++) ram[o * 8 + w] = {o[7:0], w[3:0], w[3:0]};
            if (o == 4)                ram[o * 8] = 16'h0006;
            else if (o == 5 || o == 6) ram[o * 8] = {8'h00, o[7:0]};
            else if (o == 10)          ram[o * 8] = 16'h80C8;
            else                       ram[o * 8] = {8'h80, o[7:0]};
        end
        ram[24] = 16'h8005;
        for (int w = 1; w < 8; w++) ram[24 + w] = 16'(w * 'h1111);
    endtask

    task automatic fill_ram_b();
        for (int o = 0; o < 256; o++) ram[o * 8] = 16'(o * 37);
    endtask

    task automatic dirty_cache();
        for (int i = 0; i < 2048; i++) cache[i] = 16'hDEAD;
    endtask

    task automatic run_dma(input bit k44, input bit mid_trig, input int n_obj);
        int ticks;
        int limit;
        int n;
        ticks = 1024 + 8 * n_obj + 1;
        limit = ticks * cen_div + 100;
        build_exp(k44, n_obj);
        wait_tick();
        busy_cycles = 0;
        clr_cnt     = 0;
        if (k44) dma_trig = 1'b1;
        else begin
            vs        = 1'b1;
            flick_exp = ~flick_exp;
        end
        wait_tick();
        dma_trig = 1'b0;
        chk("bsy_rise", dma_bsy, 1);
        n = 0;
        while (dma_bsy && n < limit) begin
            @(negedge clk);
            n++;
            if (mid_trig && n == 100) dma_trig = 1'b1;
            if (mid_trig && n == 101) dma_trig = 1'b0;
        end
        chk("bsy_fall_in_time", 32'(n < limit), 32'd1);
        @(negedge clk);
        vs = 1'b0;
        chk("bsy_len", busy_cycles, ticks * cen_div);
        chk("clear_ticks", clr_cnt, 1024);
        chk("writes_left", exp_q.size(), 0);
    endtask

    initial begin
        fill_ram_a();
        dirty_cache();
        repeat (3) @(negedge clk);
        chk("rst_bsy", dma_bsy, 0);
        chk("rst_we", {dma_wel, dma_weh}, 0);
        chk("rst_flicker", flicker, 0);
        chk("rst_addr", dma_addr, 0);
        chk("rst_wr_addr", dma_wr_addr, 0);
        chk("rst_din", dma_din, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            wait_tick();
            chk("idle_bsy", dma_bsy, 0);
            chk("idle_we", {dma_wel, dma_weh}, 0);
        end
        chk("idle_flicker", flicker, 0);

        vs        = 1'b1;
        flick_exp = ~flick_exp;
        repeat (5) wait_tick();
        chk("no_en_bsy", dma_bsy, 0);
        chk("flicker_no_en", flicker, flick_exp);
        vs = 1'b0;
        wait_tick();

        dma_en = 1'b1;
        run_dma(1'b0, 1'b0, 256);
        chk("k46_last_addr", dma_addr, 13'h07FF);
        chk("slot5_w0", cache[{8'd5, 3'd0}], 16'h8005);
        chk("slot5_w3", cache[{8'd5, 3'd3}], 16'h3333);
        chk("slot5_w7", cache[{8'd5, 3'd7}], 16'h7777);
        for (int w = 0; w < 8; w++) chk("slot6_clear", cache[{8'd6, w[2:0]}], 16'h0000);
        chk("collide_200", cache[{8'd200, 3'd1}], 16'hC811);
        chk("slot10_clear", cache[{8'd10, 3'd0}], 16'h0000);
        chk("flicker_k46", flicker, flick_exp);

        cen_div = 4;
        repeat (8) @(negedge clk);
        run_dma(1'b0, 1'b0, 256);
        chk("slow_slot5_w1", cache[{8'd5, 3'd1}], 16'h1111);
        chk("flicker_slow", flicker, flick_exp);
        cen_div = 1;
        repeat (8) @(negedge clk);

        k44_en    = 1'b1;
        vs        = 1'b1;
        flick_exp = ~flick_exp;
        repeat (5) wait_tick();
        chk("k44_vs_no_start", dma_bsy, 0);
        chk("flicker_k44", flicker, flick_exp);
        vs = 1'b0;
        wait_tick();

        fill_ram_b();
        dirty_cache();
        run_dma(1'b1, 1'b1, 128);
        chk("k44_last_addr", dma_addr, 13'h03FF);
        chk("k44_obj9_w0", cache[{8'd9, 3'd0}], 16'h014D);
        chk("k44_obj9_w1", cache[{8'd9, 3'd1}], 16'h0911);
        chk("k44_obj77_w0", cache[{8'd77, 3'd0}], 16'h0B21);
        chk("k44_obj200_clear", cache[{8'd200, 3'd1}], 16'h0000);
        repeat (10) wait_tick();
        chk("no_restart", dma_bsy, 0);

        k44_en = 1'b0;
        fill_ram_a();
        build_exp(1'b0, 256);
        wait_tick();
        vs = 1'b1;
        repeat (1500) wait_tick();
        chk("mid_copy_bsy", dma_bsy, 1);
        checking = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_bsy", dma_bsy, 0);
        chk("abort_we", {dma_wel, dma_weh}, 0);
        chk("abort_flicker", flicker, 0);
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checking = 1'b1;
        repeat (5) wait_tick();
        chk("post_abort_idle", dma_bsy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
